// File: rtl/fifo_write_scheduler_if.sv
// fifo_write_scheduler_if: producer handshake and FIFO write-side signals of the write scheduler
interface fifo_write_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int HALF_W  = 240
);
  logic [NUM_REQ*2*HALF_W-1:0] req_data;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        fifo_full;
  logic [HALF_W-1:0]           fifo_wrdata;
  logic                        fifo_push;
  logic                        busy;
  modport master (output req_data, req_valid, fifo_full, input req_ready, fifo_wrdata, fifo_push, busy);
  modport slave  (input req_data, req_valid, fifo_full, output req_ready, fifo_wrdata, fifo_push, busy);
endinterface

// File: rtl/fifo_write_scheduler.sv
// fifo_write_scheduler: round-robin sharing of one half-width FIFO write port between double-beat producers
module fifo_write_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int HALF_W  = 240
) (
  input logic                   clk,
  input logic                   rst,
  fifo_write_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = 2 * HALF_W;
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;
  state_t                     state, state_nx;
  logic [NUM_REQ-1:0][WW-1:0] buf_q;
  logic [NUM_REQ-1:0]         full, mask;
  logic [PW-1:0]              rr_ptr, rr_nx, grant, grant_nx, base, pick, succ;
  logic                       found, lo_done;
  // on a LO completion the search starts past the served producer, which is masked out
  always_comb begin
    succ = PW'((int'(grant) + 1) % NUM_REQ);
    lo_done = (state == LO) && !bus.fifo_full;
    base = (state == LO) ? succ : rr_ptr;
    mask = full;
    if (state == LO) mask[grant] = 1'b0;
    pick = base;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (mask[(int'(base) + k) % NUM_REQ]) begin
        pick = PW'((int'(base) + k) % NUM_REQ);
        found = 1'b1;
      end
    state_nx = state;
    grant_nx = grant;
    rr_nx = rr_ptr;
    if (state == IDLE && found) begin
      state_nx = HI;
      grant_nx = pick;
    end
    if (state == HI && !bus.fifo_full) state_nx = LO;
    if (lo_done) begin
      rr_nx = succ;
      state_nx = found ? HI : IDLE;
      grant_nx = found ? pick : grant;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      full <= '0;
      rr_ptr <= '0;
      grant <= '0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_nx;
      grant <= grant_nx;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_valid[i] && !full[i]) full[i] <= 1'b1;
        else if (lo_done && int'(grant) == i) full[i] <= 1'b0;
    end
  // buffer contents are only meaningful while full is set, so no reset is needed
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_valid[i] && !full[i]) buf_q[i] <= bus.req_data[i*WW +: WW];
  assign bus.req_ready = ~full;
  assign bus.fifo_push = (state != IDLE) && !bus.fifo_full;
  assign bus.busy = (state != IDLE) || (|full);
  assign bus.fifo_wrdata = (state == HI) ? buf_q[grant][WW-1:HALF_W] :
                           (state == LO) ? buf_q[grant][HALF_W-1:0] : '0;
endmodule

// File: tb/tb_fifo_write_scheduler.sv
// tb_fifo_write_scheduler: directed checks of the write scheduler with two and four producers
module tb_fifo_write_scheduler;
  localparam int HW = 240;
  localparam logic [HW-1:0] HA = {60{4'hA}};
  localparam logic [HW-1:0] L5 = {60{4'h5}};
  localparam logic [HW-1:0] H0 = 240'h100;
  localparam logic [HW-1:0] L0 = 240'h101;
  localparam logic [HW-1:0] H1 = 240'h200;
  localparam logic [HW-1:0] L1 = 240'h201;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  fifo_write_scheduler_if #(.NUM_REQ(2), .HALF_W(HW)) ba();
  fifo_write_scheduler_if #(.NUM_REQ(4), .HALF_W(HW)) bb();
  fifo_write_scheduler #(.NUM_REQ(2), .HALF_W(HW)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  fifo_write_scheduler #(.NUM_REQ(4), .HALF_W(HW)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat_a(input string tag, input logic [HW-1:0] exp);
    check({tag, " push"}, ba.fifo_push, 1);
    check({tag, " data"}, ba.fifo_wrdata, exp);
  endtask
  task automatic beat_b(input string tag, input logic [HW-1:0] exp);
    check({tag, " push"}, bb.fifo_push, 1);
    check({tag, " data"}, bb.fifo_wrdata, exp);
  endtask
  task automatic do_reset;
    rst = 1'b0;
    ba.req_valid = '0;
    bb.req_valid = '0;
    ba.fifo_full = 1'b0;
    bb.fifo_full = 1'b0;
    tick;
    rst = 1'b1;
  endtask
  initial begin
    ba.req_data = '0;
    ba.req_valid = '0;
    ba.fifo_full = 1'b0;
    bb.req_data = '0;
    bb.req_valid = '0;
    bb.fifo_full = 1'b0;
    tick;
    tick;
    check("rst push", ba.fifo_push, 0);
    check("rst data", ba.fifo_wrdata, 0);
    check("rst busy", ba.busy, 0);
    check("rst ready", ba.req_ready, 2'b11);
    check("rst ready b", bb.req_ready, 4'hF);
    rst = 1'b1;
    // single word: capture, then upper and lower beats on consecutive cycles
    ba.req_data[479:0] = {HA, L5};
    ba.req_valid = 2'b01;
    tick;
    ba.req_valid = '0;
    #1;
    check("sw ready e0", ba.req_ready, 2'b10);
    check("sw push e0", ba.fifo_push, 0);
    check("sw busy e0", ba.busy, 1);
    tick;
    beat_a("sw hi", HA);
    tick;
    beat_a("sw lo", L5);
    check("sw ready e2", ba.req_ready, 2'b10);
    tick;
    check("sw push e3", ba.fifo_push, 0);
    check("sw ready e3", ba.req_ready, 2'b11);
    check("sw busy e3", ba.busy, 0);
    // contention: simultaneous captures served from rr_ptr=0, twice
    do_reset;
    for (int r = 0; r < 2; r++) begin
      ba.req_data = {H1, L1, H0, L0};
      ba.req_valid = 2'b11;
      tick;
      ba.req_valid = '0;
      tick;
      beat_a("ct p0hi", H0);
      tick;
      beat_a("ct p0lo", L0);
      tick;
      beat_a("ct p1hi", H1);
      tick;
      beat_a("ct p1lo", L1);
      tick;
      check("ct idle push", ba.fifo_push, 0);
    end
    // fairness: both producers re-present immediately, grants alternate with no gaps
    do_reset;
    ba.req_data = {H1, L1, H0, L0};
    ba.req_valid = 2'b11;
    tick;
    for (int r = 0; r < 3; r++) begin
      tick;
      beat_a("fr p0hi", H0);
      tick;
      beat_a("fr p0lo", L0);
      tick;
      beat_a("fr p1hi", H1);
      tick;
      beat_a("fr p1lo", L1);
    end
    // backpressure in LO for three cycles
    do_reset;
    ba.req_data = {H1, L1, H0, L0};
    ba.req_valid = 2'b11;
    tick;
    ba.req_valid = '0;
    tick;
    beat_a("bp hi", H0);
    tick;
    ba.fifo_full = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick;
      check("bp stall push", ba.fifo_push, 0);
      check("bp stall data", ba.fifo_wrdata, L0);
    end
    tick;
    ba.fifo_full = 1'b0;
    #1;
    beat_a("bp lo", L0);
    check("bp busy", ba.busy, 1);
    tick;
    beat_a("bp p1hi", H1);
    tick;
    beat_a("bp p1lo", L1);
    // asynchronous reset between the halves of a pair
    do_reset;
    ba.req_data = {H1, L1, H0, L0};
    ba.req_valid = 2'b01;
    tick;
    ba.req_valid = '0;
    tick;
    beat_a("mr hi", H0);
    tick;
    rst = 1'b0;
    #1;
    check("mr push", ba.fifo_push, 0);
    check("mr busy", ba.busy, 0);
    check("mr ready", ba.req_ready, 2'b11);
    check("mr data", ba.fifo_wrdata, 0);
    tick;
    rst = 1'b1;
    ba.req_data[479:0] = {HA, L5};
    ba.req_valid = 2'b01;
    tick;
    ba.req_valid = '0;
    tick;
    beat_a("mr new hi", HA);
    tick;
    beat_a("mr new lo", L5);
    // four producers captured together
    do_reset;
    for (int k = 0; k < 4; k++) bb.req_data[k*480 +: 480] = {HW'('hB0 + k), HW'('hC0 + k)};
    bb.req_valid = 4'hF;
    tick;
    bb.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      beat_b("q hi", HW'('hB0 + k));
      tick;
      beat_b("q lo", HW'('hC0 + k));
      check("q busy", bb.busy, 1);
    end
    tick;
    check("q end push", bb.fifo_push, 0);
    check("q end busy", bb.busy, 0);
    check("q end ready", bb.req_ready, 4'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
